calc_key_sequencer: RTL and testbench
=====================================

// Module: calc_key_sequencer
// PURPOSE
//  Upstream front end of the table adder. Takes a stream of calculator key
//  codes, parses "digit + digit =" and drives data1/data2/op so the adder
//  latches data1+data2 when op==OP_EQUAL. Input keys are buffered in a small
//  FIFO and parsed by a registered FSM, one key per clock.
// PARAMETERS
//  DATA_W      4  operand width (data1/data2)
//  KEY_W       4  key code width
//  FIFO_DEPTH  2  key buffer depth (power of 2, >=2)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  key_valid  in   1       key_code valid this cycle
//  key_code   in   KEY_W   0x0-0x9 digit, 0xA '+', 0xB '=', 0xC clear, 0xD-0xF illegal
//  key_ready  out  1       key accepted when key_valid&key_ready
//  data1      out  DATA_W  first operand (registered)
//  data2      out  DATA_W  second operand (registered)
//  op         out  4       OP_NONE=0, OP_ADD=1, OP_EQUAL=2 (registered)
//  err_pulse  out  1       1-cycle pulse on illegal/out-of-order key
//  busy       out  1       FSM not in S_IDLE or FIFO not empty
// BEHAVIOUR
//  Reset: data1=data2=0, op=OP_NONE, err_pulse=0, FSM=S_IDLE, FIFO empty, so
//   key_ready=1, busy=0.
//  FIFO: key_ready = !full; no pass-through. Push on key_valid&key_ready. When
//   the FIFO is full, a push is refused even if a pop happens in the same
//   cycle. Pointers wrap modulo FIFO_DEPTH.
//  Pop: one key per cycle when the FIFO is not empty and FSM != S_EMIT.
//  Latency: key accepted at edge N -> outputs and state update at edge N+1
//   (FIFO was empty, no stall).
//  FSM (key -> next state, action):
//   S_IDLE: digit -> S_A, data1=digit.
//   S_A:    digit -> S_A, data1 overwritten. '+' -> S_OP, op=OP_ADD.
//   S_OP:   digit -> S_B, data2=digit.
//   S_B:    digit -> S_B, data2 overwritten. '=' -> S_EMIT, op=OP_EQUAL.
//   S_EMIT: exactly 1 cycle, no pop. Then op=OP_NONE and go to S_IDLE.
//   Clear (0xC) in any popping state: go to S_IDLE, data1=data2=0, op=OP_NONE.
//    Remaining FIFO entries are kept.
//   Out-of-order key ('+' or '=' in S_IDLE or S_OP, '=' in S_A, '+' in S_B) or
//    0xD-0xF: err_pulse=1 for one cycle. Key is consumed; state and data are
//    unchanged.
//  data1/data2 hold after S_EMIT until overwritten by the next digit or clear.
//  Digits zero-extend into DATA_W.
//  op==OP_EQUAL is high for exactly one cycle per completed expression.
//  rst_n assertion mid-expression: return to the reset values immediately
//   (asynchronous); FIFO contents are discarded.
// STRUCTURE
//  Shared package calc_pkg: KEY_ADD=4'hA, KEY_EQUAL=4'hB, KEY_CLR=4'hC,
//   OP_NONE/OP_ADD/OP_EQUAL codes, FSM state enum. The adder uses the same
//   OP_EQUAL constant.
//  Sub-module calc_key_fifo (params WIDTH, DEPTH; push/pop/full/empty, async
//   reset). The FSM and output registers stay in this module.
// TESTING
//  1. Keys 3,+,4,= back-to-back -> op sequence ADD then EQUAL for 1 cycle with
//     data1=3, data2=4, then op=NONE. Adder output = 7.
//  2. Keys 5,2,+,9,1,= -> EQUAL with data1=2, data2=1. No err_pulse.
//  3. Keys +, =, 0xE from S_IDLE -> 3 err_pulses, state S_IDLE, op=NONE throughout.
//  4. Hold key_valid=1 for 4 cycles from reset (FIFO_DEPTH=2) -> key_ready
//     drops when full. No key lost or duplicated. Stall observed during S_EMIT.
//  5. Keys 7,+,0xC,1,+,1,= -> after clear data1=data2=0, then EQUAL with
//     data1=1, data2=1.
//  6. Assert rst_n low in S_OP with 1 key buffered -> all outputs at reset
//     values, key_ready=1, busy=0 at the next cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, adder op codes and parser state encoding for the calculator front end.
package calc_pkg;

    localparam logic [3:0] KEY_DIG_MAX = 4'h9;
    localparam logic [3:0] KEY_ADD     = 4'hA;
    localparam logic [3:0] KEY_EQUAL   = 4'hB;
    localparam logic [3:0] KEY_CLR     = 4'hC;

    localparam logic [3:0] OP_NONE     = 4'd0;
    localparam logic [3:0] OP_ADD      = 4'd1;
    localparam logic [3:0] OP_EQUAL    = 4'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A,
        S_OP,
        S_B,
        S_EMIT
    } state_e;

endpackage

// File: rtl/calc_key_fifo.sv
// Small key buffer; push visible on pop side one edge later (no pass-through).
// Push refused whenever full, even with a simultaneous pop; pop ignored when empty.
module calc_key_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o    = (count_q == DEPTH_CNT);
    assign empty_o   = (count_q == '0);
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Parses "digit + digit =" key streams into data1/data2/op for the adder; key popped at edge N+1 after accept.
// key_ready drops when the key buffer is full; parser stalls popping for the single S_EMIT cycle.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int KEY_W      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_code,
    output logic              key_ready,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [3:0]        op,
    output logic              err_pulse,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
    logic [3:0]        op_q, op_d;
    logic              err_q, err_d;

    logic              fifo_full, fifo_empty, pop;
    logic [KEY_W-1:0]  key;
    logic              is_digit, is_add, is_equal, is_clr;

    calc_key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (key_valid),
        .push_dat_i (key_code),
        .full_o     (fifo_full),
        .pop_i      (pop),
        .pop_dat_o  (key),
        .empty_o    (fifo_empty)
    );

    assign key_ready = !fifo_full;
    assign pop       = !fifo_empty && (state_q != S_EMIT);
    assign busy      = (state_q != S_IDLE) || !fifo_empty;

    assign is_digit  = (key <= KEY_W'(KEY_DIG_MAX));
    assign is_add    = (key == KEY_W'(KEY_ADD));
    assign is_equal  = (key == KEY_W'(KEY_EQUAL));
    assign is_clr    = (key == KEY_W'(KEY_CLR));

    always_comb begin
        state_d = state_q;
        data1_d = data1_q;
        data2_d = data2_q;
        op_d    = op_q;
        err_d   = 1'b0;

        if (state_q == S_EMIT) begin
            op_d    = OP_NONE;
            state_d = S_IDLE;
        end else if (pop) begin
            if (is_clr) begin
                state_d = S_IDLE;
                data1_d = '0;
                data2_d = '0;
                op_d    = OP_NONE;
            end else if (is_digit) begin
                // Digits in S_IDLE/S_A feed data1, in S_OP/S_B feed data2.
                if (state_q == S_IDLE || state_q == S_A) begin
                    state_d = S_A;
                    data1_d = DATA_W'(key);
                end else begin
                    state_d = S_B;
                    data2_d = DATA_W'(key);
                end
            end else if (is_add && state_q == S_A) begin
                state_d = S_OP;
                op_d    = OP_ADD;
            end else if (is_equal && state_q == S_B) begin
                state_d = S_EMIT;
                op_d    = OP_EQUAL;
            end else begin
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data1_q <= '0;
            data2_q <= '0;
            op_q    <= OP_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign data1     = data1_q;
    assign data2     = data2_q;
    assign op        = op_q;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench: a reference parser predicts each completed expression when keys are driven.
module tb_calc_key_sequencer;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_ready;
    logic [3:0] data1, data2, op;
    logic       err_pulse, busy;

    calc_key_sequencer #(.DATA_W(4), .KEY_W(4), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .data1     (data1),
        .data2     (data2),
        .op        (op),
        .err_pulse (err_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d1;
        int d2;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_err = 0;
    int   obs_err = 0;
    int   m_state = 0;   // 0 idle, 1 A, 2 OP, 3 B
    int   m_d1 = 0, m_d2 = 0;
    bit   saw_stall = 0;
    bit   prev_eq = 0;
    int   prev_op = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_key(input logic [3:0] k);
        if (k == KEY_CLR) begin
            m_state = 0; m_d1 = 0; m_d2 = 0;
        end else if (k <= 4'h9) begin
            if (m_state <= 1) begin m_state = 1; m_d1 = int'(k); end
            else              begin m_state = 3; m_d2 = int'(k); end
        end else if (k == KEY_ADD && m_state == 1) begin
            m_state = 2;
        end else if (k == KEY_EQUAL && m_state == 3) begin
            exp_t e;
            e.d1 = m_d1; e.d2 = m_d2;
            sb.push_back(e);
            m_state = 0;
        end else begin
            exp_err++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the key was accepted.
    task automatic send(input logic [3:0] k);
        int guard = 0;
        key_valid = 1'b1;
        key_code  = k;
        model_key(k);
        while (!key_ready && guard < 100) begin
            saw_stall = 1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("send_timeout", int'(key_ready), 1);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        key_valid = 1'b0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk({tag, "_idle_timeout"}, int'(busy), 0);
        @(negedge clk);
        #1;
        chk({tag, "_data1"}, int'(data1), m_d1);
        chk({tag, "_data2"}, int'(data2), m_d2);
        chk({tag, "_op"}, int'(op), int'(OP_NONE));
        chk({tag, "_errs"}, obs_err, exp_err);
        chk({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_eq = 0;
            prev_op = 0;
        end else begin
            if (prev_eq) chk("eq_one_cycle", int'(op), int'(OP_NONE));
            if (op == OP_EQUAL) begin
                chk("eq_after_add", prev_op, int'(OP_ADD));
                chk("eq_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("eq_data1", int'(data1), e.d1);
                    chk("eq_data2", int'(data2), e.d2);
                    chk("adder_sum", int'(data1) + int'(data2), e.d1 + e.d2);
                end
            end
            if (err_pulse) obs_err++;
            prev_eq = (op == OP_EQUAL);
            prev_op = int'(op);
        end
    end

    initial begin
        #2;
        chk("rst_data1", int'(data1), 0);
        chk("rst_data2", int'(data2), 0);
        chk("rst_op", int'(op), int'(OP_NONE));
        chk("rst_err", int'(err_pulse), 0);
        chk("rst_ready", int'(key_ready), 1);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: back-to-back simple add
        send(4'h3); send(KEY_ADD); send(4'h4); send(KEY_EQUAL);
        wait_idle("t1");

        // 2: operand overwrite
        send(4'h5); send(4'h2); send(KEY_ADD); send(4'h9); send(4'h1); send(KEY_EQUAL);
        wait_idle("t2");

        // 3: out-of-order and illegal keys from idle
        send(KEY_ADD); send(KEY_EQUAL); send(4'hE);
        wait_idle("t3");
        chk("t3_err3", exp_err, 3);

        // 4: continuous burst; the emit cycle must back up the buffer
        saw_stall = 0;
        send(4'h1); send(KEY_ADD); send(4'h2); send(KEY_EQUAL);
        send(4'h5); send(KEY_ADD); send(4'h6); send(KEY_EQUAL);
        send(4'h7); send(KEY_ADD); send(4'hF); send(4'h8); send(KEY_EQUAL);
        wait_idle("t4");
        chk("t4_stall_seen", int'(saw_stall), 1);

        // 5: clear mid-expression
        send(4'h7); send(KEY_ADD); send(KEY_CLR);
        wait_idle("t5a");
        send(4'h1); send(KEY_ADD); send(4'h1); send(KEY_EQUAL);
        wait_idle("t5b");

        // 6: async reset in S_OP with one key buffered
        send(4'h3); send(KEY_ADD);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_pre_op", int'(op), int'(OP_ADD));
        key_valid = 1'b1;
        key_code  = 4'h4;
        @(posedge clk);
        #1;
        chk("t6_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        key_valid = 1'b0;
        #1;
        chk("t6_async_op", int'(op), int'(OP_NONE));
        chk("t6_async_data1", int'(data1), 0);
        @(negedge clk);
        chk("t6_data1", int'(data1), 0);
        chk("t6_data2", int'(data2), 0);
        chk("t6_op", int'(op), int'(OP_NONE));
        chk("t6_err", int'(err_pulse), 0);
        chk("t6_ready", int'(key_ready), 1);
        chk("t6_busy", int'(busy), 0);
        m_state = 0; m_d1 = 0; m_d2 = 0;
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);

        // post-reset sanity: buffered key must not reappear
        send(4'h8); send(KEY_ADD); send(4'h8); send(KEY_EQUAL);
        wait_idle("t6_post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
